// File: rtl/morty_ex_pkg.sv
// Shared encodings for the morty execute stage: M-extension funct3 codes,
// multiply/divide FSM states, ALU operations and operand-signedness decode.
package morty_ex_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASB = 4'd10;

    // Returns {a_signed, b_signed}. MUL is treated as unsigned since the low
    // half of the product does not depend on operand signedness.
    function automatic logic [1:0] md_signed_ops(input logic [2:0] op);
        logic [1:0] sgn;
        sgn = 2'b00;
        case (op)
            MD_MULH, MD_DIV, MD_REM: sgn = 2'b11;
            MD_MULHSU:               sgn = 2'b10;
            default:                 sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/morty_exu.sv
// Combinational ALU for the morty execute stage.
module morty_exu
    import morty_ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_PASB: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/morty_muldiv.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand
// magnitudes, one step per cycle, with sign correction applied in DONE.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   MD_IDLE | waiting for start; operands latched on the start edge
//   MD_CALC | one multiply/divide step per cycle, counter runs down
//   MD_DONE | sign-corrected result valid; leaves on ack or abort
module morty_muldiv
    import morty_ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            abort,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             neg_q;
    logic             neg_r;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  opnd;

    logic [1:0]       sgn;
    logic             sign_a;
    logic             sign_b;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic             is_div;
    logic             div_zero;
    logic             div_ovf;
    logic             go;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic [XLEN:0]    div_diff;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quo_c;
    logic [XLEN-1:0]   rem_c;

    assign sgn      = md_signed_ops(op);
    assign sign_a   = sgn[1] & a[XLEN-1];
    assign sign_b   = sgn[0] & b[XLEN-1];
    assign mag_a    = sign_a ? -a : a;
    assign mag_b    = sign_b ? -b : b;
    assign is_div   = op[2];
    assign div_zero = is_div & (b == '0);
    assign div_ovf  = is_div & sgn[1] & (a == XMIN) & (b == '1);
    assign go       = start & ~abort;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            op_q   <= MD_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (go) begin
                        op_q <= op;
                        // Special cases park their final values in the
                        // accumulators so DONE needs no extra result path.
                        if (div_zero) begin
                            acc_lo <= '1;
                            acc_hi <= a;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            cnt    <= '0;
                            state  <= MD_DONE;
                        end else if (div_ovf) begin
                            acc_lo <= XMIN;
                            acc_hi <= '0;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            cnt    <= '0;
                            state  <= MD_DONE;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= is_div ? mag_a : mag_b;
                            opnd   <= is_div ? mag_b : mag_a;
                            neg_q  <= sign_a ^ sign_b;
                            neg_r  <= sign_a;
                            cnt    <= CNT_W'(XLEN);
                            state  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (abort) begin
                        cnt   <= '0;
                        state <= MD_IDLE;
                    end else begin
                        if (op_q[2]) begin
                            if (!div_diff[XLEN]) begin
                                acc_hi <= div_diff[XLEN-1:0];
                                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[XLEN-1:0];
                                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[XLEN:1];
                            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= MD_DONE;
                        end
                    end
                end
                MD_DONE: begin
                    if (abort || ack) begin
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign prod   = {acc_hi, acc_lo};
    assign prod_c = neg_q ? -prod : prod;
    assign quo_c  = neg_q ? -acc_lo : acc_lo;
    assign rem_c  = neg_r ? -acc_hi : acc_hi;

    always_comb begin
        result = '0;
        case (op_q)
            MD_MUL:                       result = prod_c[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_c[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = quo_c;
            default:                      result = rem_c;
        endcase
    end

    assign busy = ((state == MD_IDLE) & go) | (state == MD_CALC);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/morty_ex_stage_md.sv
// morty execute stage: combinational ALU, iterative mul/div unit and the
// EX/MEM pipeline register with a packed pass-through sideband.
module morty_ex_stage_md
    import morty_ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SB_W  = 128,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_port_a_i,
    input  logic [XLEN-1:0] ex_port_b_i,
    input  logic [3:0]      ex_alu_op_i,
    input  logic            ex_md_en_i,
    input  logic [2:0]      ex_md_op_i,
    input  logic [4:0]      ex_waddr_i,
    input  logic            ex_we_i,
    input  logic [SB_W-1:0] ex_sideband_i,
    input  logic            mem_stall_i,
    input  logic            mem_bubble_i,
    output logic            ex_stall_o,
    output logic [XLEN-1:0] ex_fwd_dat_o,
    output logic            ex_fwd_valid_o,
    output logic            mem_valid_o,
    output logic [XLEN-1:0] mem_result_o,
    output logic [4:0]      mem_waddr_o,
    output logic            mem_we_o,
    output logic [SB_W-1:0] mem_sideband_o
);

    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] md_result;
    logic            md_start;
    logic            md_ack;
    logic            md_busy;
    logic            md_done;

    assign md_start = ex_valid_i & ex_md_en_i & ~mem_bubble_i;
    assign md_ack   = ~mem_stall_i;

    morty_exu #(
        .XLEN (XLEN)
    ) u_exu (
        .a      (ex_port_a_i),
        .b      (ex_port_b_i),
        .op     (ex_alu_op_i),
        .result (alu_result)
    );

    morty_muldiv #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (md_start),
        .op     (ex_md_op_i),
        .a      (ex_port_a_i),
        .b      (ex_port_b_i),
        .abort  (mem_bubble_i),
        .ack    (md_ack),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // busy covers the start cycle and CALC; mem_stall covers IDLE and DONE.
    assign ex_stall_o     = rst_i & (md_busy | mem_stall_i);
    assign ex_fwd_dat_o   = md_done ? md_result : alu_result;
    assign ex_fwd_valid_o = md_done | (~md_busy & ex_valid_i & ~ex_md_en_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_valid_o    <= 1'b0;
            mem_result_o   <= '0;
            mem_waddr_o    <= '0;
            mem_we_o       <= 1'b0;
            mem_sideband_o <= '0;
        end else if (mem_bubble_i) begin
            mem_valid_o    <= 1'b0;
            mem_result_o   <= '0;
            mem_waddr_o    <= '0;
            mem_we_o       <= 1'b0;
            mem_sideband_o <= '0;
        end else if (!mem_stall_i) begin
            mem_waddr_o    <= ex_waddr_i;
            mem_sideband_o <= ex_sideband_i;
            if (md_done) begin
                mem_valid_o  <= 1'b1;
                mem_we_o     <= ex_we_i;
                mem_result_o <= md_result;
            end else if (md_busy) begin
                mem_valid_o  <= 1'b0;
                mem_we_o     <= 1'b0;
                mem_result_o <= alu_result;
            end else begin
                mem_valid_o  <= ex_valid_i;
                mem_we_o     <= ex_valid_i & ex_we_i;
                mem_result_o <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_morty_ex_stage_md.sv
// Scoreboard bench for morty_ex_stage_md: directed ops push expected EX/MEM
// contents; a monitor pops and compares whenever an entry leaves EX/MEM.
module tb_morty_ex_stage_md;
    import morty_ex_pkg::*;

    localparam int XLEN = 32;
    localparam int SB_W = 128;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            ex_valid_i;
    logic [XLEN-1:0] ex_port_a_i;
    logic [XLEN-1:0] ex_port_b_i;
    logic [3:0]      ex_alu_op_i;
    logic            ex_md_en_i;
    logic [2:0]      ex_md_op_i;
    logic [4:0]      ex_waddr_i;
    logic            ex_we_i;
    logic [SB_W-1:0] ex_sideband_i;
    logic            mem_stall_i;
    logic            mem_bubble_i;
    logic            ex_stall_o;
    logic [XLEN-1:0] ex_fwd_dat_o;
    logic            ex_fwd_valid_o;
    logic            mem_valid_o;
    logic [XLEN-1:0] mem_result_o;
    logic [4:0]      mem_waddr_o;
    logic            mem_we_o;
    logic [SB_W-1:0] mem_sideband_o;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      wa;
        logic [SB_W-1:0] sb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    morty_ex_stage_md #(.XLEN(XLEN), .SB_W(SB_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ex_valid_i     (ex_valid_i),
        .ex_port_a_i    (ex_port_a_i),
        .ex_port_b_i    (ex_port_b_i),
        .ex_alu_op_i    (ex_alu_op_i),
        .ex_md_en_i     (ex_md_en_i),
        .ex_md_op_i     (ex_md_op_i),
        .ex_waddr_i     (ex_waddr_i),
        .ex_we_i        (ex_we_i),
        .ex_sideband_i  (ex_sideband_i),
        .mem_stall_i    (mem_stall_i),
        .mem_bubble_i   (mem_bubble_i),
        .ex_stall_o     (ex_stall_o),
        .ex_fwd_dat_o   (ex_fwd_dat_o),
        .ex_fwd_valid_o (ex_fwd_valid_o),
        .mem_valid_o    (mem_valid_o),
        .mem_result_o   (mem_result_o),
        .mem_waddr_o    (mem_waddr_o),
        .mem_we_o       (mem_we_o),
        .mem_sideband_o (mem_sideband_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [SB_W-1:0] act, input logic [SB_W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [SB_W-1:0] mk_sb(input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        return {a, b, ~a, 27'd0, wa};
    endfunction

    task automatic drive_idle();
        ex_valid_i    = 1'b0;
        ex_md_en_i    = 1'b0;
        ex_alu_op_i   = ALU_ADD;
        ex_md_op_i    = MD_MUL;
        ex_port_a_i   = '0;
        ex_port_b_i   = '0;
        ex_waddr_i    = '0;
        ex_we_i       = 1'b0;
        ex_sideband_i = '0;
    endtask

    task automatic set_in(input logic md, input logic [3:0] aop, input logic [2:0] mop,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        ex_valid_i    = 1'b1;
        ex_md_en_i    = md;
        ex_alu_op_i   = aop;
        ex_md_op_i    = mop;
        ex_port_a_i   = a;
        ex_port_b_i   = b;
        ex_waddr_i    = wa;
        ex_we_i       = 1'b1;
        ex_sideband_i = mk_sb(a, b, wa);
    endtask

    // Called just after a rising edge; returns just after the capturing edge.
    task automatic run_op(input string name, input logic md, input logic [3:0] aop, input logic [2:0] mop,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp_res, input int exp_stall);
        exp_t e;
        int   n;
        bit   ok;
        set_in(md, aop, mop, a, b, wa);
        e.res = exp_res;
        e.wa  = wa;
        e.sb  = mk_sb(a, b, wa);
        exp_q.push_back(e);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!ex_stall_o) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            total++;
            $display("FAIL %s_timeout: stall still high after %0d cycles", name, n);
        end
        check({name, "_stall_cycles"}, SB_W'(n), SB_W'(exp_stall));
        @(posedge clk_i);
        #1;
        check({name, "_latency"}, SB_W'(mem_valid_o), SB_W'(1));
        drive_idle();
    endtask

    // Monitor: an EX/MEM entry is consumed on any cycle it is valid and not stalled.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && mem_valid_o && !mem_stall_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_mem_valid: got result %0h waddr %0d expected no entry", mem_result_o, mem_waddr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_result", SB_W'(mem_result_o), SB_W'(mon_e.res));
                    check("sb_waddr", SB_W'(mem_waddr_o), SB_W'(mon_e.wa));
                    check("sb_we", SB_W'(mem_we_o), SB_W'(1));
                    check("sb_sideband", mem_sideband_o, mon_e.sb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        exp_t e;
        rst_i        = 1'b0;
        mem_stall_i  = 1'b0;
        mem_bubble_i = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk_i);
        check("rst_mem_valid", SB_W'(mem_valid_o), '0);
        check("rst_mem_result", SB_W'(mem_result_o), '0);
        check("rst_mem_we", SB_W'(mem_we_o), '0);
        check("rst_ex_stall", SB_W'(ex_stall_o), '0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        run_op("add",    1'b0, ALU_ADD, MD_MUL,    32'd5,        32'd7,        5'd1,  32'd12,       0);
        run_op("sub",    1'b0, ALU_SUB, MD_MUL,    32'd3,        32'd5,        5'd2,  32'hFFFFFFFE, 0);
        run_op("mul",    1'b1, ALU_ADD, MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
        run_op("mulhu",  1'b1, ALU_ADD, MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 33);
        run_op("div_ovf",1'b1, ALU_ADD, MD_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h80000000, 1);
        run_op("divu_z", 1'b1, ALU_ADD, MD_DIVU,   32'd9,        32'd0,        5'd6,  32'hFFFFFFFF, 1);
        run_op("rem_z",  1'b1, ALU_ADD, MD_REM,    32'd9,        32'd0,        5'd7,  32'd9,        1);
        run_op("rem_neg",1'b1, ALU_ADD, MD_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
        run_op("div_neg",1'b1, ALU_ADD, MD_DIV,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 33);
        run_op("mulh",   1'b1, ALU_ADD, MD_MULH,   32'hFFFFFFFE, 32'd3,        5'd12, 32'hFFFFFFFF, 33);
        run_op("mulhsu", 1'b1, ALU_ADD, MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFF, 33);

        // Abort a divide in CALC cycle 10; nothing may reach EX/MEM.
        set_in(1'b1, ALU_ADD, MD_DIVU, 32'd100, 32'd7, 5'd20);
        repeat (10) @(posedge clk_i);
        #1 mem_bubble_i = 1'b1;
        @(negedge clk_i);
        check("bubble_calc_stall", SB_W'(ex_stall_o), SB_W'(1));
        @(posedge clk_i);
        #1;
        mem_bubble_i = 1'b0;
        drive_idle();
        @(negedge clk_i);
        check("bubble_idle_stall", SB_W'(ex_stall_o), '0);
        check("bubble_no_valid", SB_W'(mem_valid_o), '0);
        repeat (40) @(posedge clk_i);
        #1;
        run_op("add_after_bubble", 1'b0, ALU_ADD, MD_MUL, 32'd1, 32'd2, 5'd9, 32'd3, 0);

        // MULH held in DONE by a three-cycle downstream stall.
        set_in(1'b1, ALU_ADD, MD_MULH, 32'h40000000, 32'h40000000, 5'd10);
        e.res = 32'h10000000;
        e.wa  = 5'd10;
        e.sb  = mk_sb(32'h40000000, 32'h40000000, 5'd10);
        exp_q.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (ex_fwd_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL mulh_done_timeout: fwd_valid 0 expected 1");
        end
        mem_stall_i = 1'b1;
        #1;
        check("hold_stall", SB_W'(ex_stall_o), SB_W'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("hold_fwd_dat", SB_W'(ex_fwd_dat_o), SB_W'(32'h10000000));
            check("hold_no_capture", SB_W'(mem_valid_o), '0);
        end
        mem_stall_i = 1'b0;
        #1;
        check("hold_release_stall", SB_W'(ex_stall_o), '0);
        @(posedge clk_i);
        #1;
        check("hold_capture", SB_W'(mem_valid_o), SB_W'(1));
        drive_idle();
        @(posedge clk_i);
        #1;
        check("hold_single_pulse", SB_W'(mem_valid_o), '0);

        // Reset in the middle of a multiply.
        set_in(1'b1, ALU_ADD, MD_MUL, 32'd3, 32'd5, 5'd21);
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        check("midrst_valid", SB_W'(mem_valid_o), '0);
        check("midrst_result", SB_W'(mem_result_o), '0);
        check("midrst_waddr", SB_W'(mem_waddr_o), '0);
        check("midrst_we", SB_W'(mem_we_o), '0);
        check("midrst_sideband", mem_sideband_o, '0);
        check("midrst_stall", SB_W'(ex_stall_o), '0);
        drive_idle();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        run_op("divu_post_rst", 1'b1, ALU_ADD, MD_DIVU, 32'd10, 32'd3, 5'd14, 32'd3, 33);

        repeat (5) @(negedge clk_i);
        check("queue_empty", SB_W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/morty_ex_stage_md.md
Name: morty_ex_stage_md

Overview:
Parametrised execute stage for the morty pipeline.
- Adds an iterative RV32M multiply/divide unit beside the combinational ALU (morty_exu), plus the EX/MEM pipeline register.
- Generalised over data width (XLEN) and over a packed sideband bundle (SB_W), so pc, instruction, mem flags, CSR and exception fields pass through as one vector.
- Stalls upstream while a multi-cycle M-op is in flight.

Parameters:
- XLEN, 32: datapath width; must be even and at least 8.
- SB_W, 128: width of the pass-through sideband bundle.
- CNT_W, $clog2(XLEN+1): iteration counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- ex_valid_i  in  1  EX holds a valid instruction
- ex_port_a_i  in  XLEN  operand A
- ex_port_b_i  in  XLEN  operand B
- ex_alu_op_i  in  4  ALU operation
- ex_md_en_i  in  1  instruction is an M-extension op
- ex_md_op_i  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- ex_waddr_i  in  5  destination register
- ex_we_i  in  1  register write enable
- ex_sideband_i  in  SB_W  pass-through fields
- mem_stall_i  in  1  hold EX/MEM
- mem_bubble_i  in  1  flush EX/MEM and abort the M-op
- ex_stall_o  out  1  upstream must hold EX
- ex_fwd_dat_o  out  XLEN  forwarding data
- ex_fwd_valid_o  out  1  ex_fwd_dat_o is final
- mem_valid_o  out  1  registered valid
- mem_result_o  out  XLEN  registered result
- mem_waddr_o  out  5  registered destination
- mem_we_o  out  1  registered write enable
- mem_sideband_o  out  SB_W  registered sideband

Behaviour:
Reset
- rst_i low asynchronously clears all mem_* outputs to 0.
- FSM goes to IDLE and the counter to 0.
- ex_stall_o is 0 during reset.

Non-M instructions (ex_md_en_i=0)
- ALU result is combinational.
- ex_fwd_valid_o = ex_valid_i.
- Captured into EX/MEM on the next edge: one cycle latency.

FSM states: IDLE, CALC, DONE.
- IDLE → CALC: ex_valid_i & ex_md_en_i & !mem_bubble_i. Latch the operand magnitudes, the result signs and the op; counter = XLEN. ex_stall_o=1 combinationally in this cycle.
- IDLE → DONE (special case, no CALC):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
- CALC:
  - Multiply: one shift-add step per cycle on the unsigned magnitudes.
  - Divide: one restoring step per cycle.
  - Counter decrements each step; at counter==1 go to DONE.
  - ex_stall_o=1 and ex_fwd_valid_o=0 throughout.
- DONE:
  - Apply sign correction: negate the 2·XLEN product if signs differ; quotient sign = sign A XOR sign B; remainder takes the sign of A.
  - Result selection: MUL gives the low half; MULH/MULHSU/MULHU give the high half.
  - ex_fwd_dat_o = result, ex_fwd_valid_o=1, ex_stall_o = mem_stall_i.
  - If !mem_stall_i: EX/MEM captures and the FSM returns to IDLE.
  - Otherwise hold DONE and the result.
- Latency: a normal M-op occupies EX for XLEN+2 cycles; a special case for 2 cycles.
- Operand signedness:
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - MUL: sign is irrelevant to the low half.

EX/MEM register
- Priority: flush > stall > load.
- Flush clears mem_valid_o and mem_we_o; the other fields may be zeroed.
- While the M-op is not in DONE, the register loads a bubble (valid=0, we=0) so nothing is duplicated downstream.

Flush and stall interaction
- mem_bubble_i in CALC or DONE aborts to IDLE on the same edge; no partial result is ever written.
- mem_stall_i has no effect on CALC progress; only the DONE handoff waits.
- ex_stall_o = (M-op start in IDLE) | CALC | (DONE & mem_stall_i) | (IDLE & mem_stall_i).

Decomposition:
- Package morty_ex_pkg holds:
  - md_op encodings (MD_MUL=3'b000 … MD_REMU=3'b111)
  - the FSM state enum
  - ALU op constants
  - a helper function for signed-operand selection per op
- Sub-module morty_muldiv (parameter XLEN) holds the FSM, counter and datapath.
  - Interface: start, op, a, b, abort, ack → busy, done, result.
- The top level instantiates morty_exu, morty_muldiv and the EX/MEM register logic.

Test Plan:
- ALU ADD 5+7, no stall → mem_result_o=12, mem_valid_o=1 one cycle later; ex_stall_o stays 0.
- MUL 7 × 0xFFFFFFFD (XLEN=32) → ex_stall_o high 33 cycles; mem_result_o=0xFFFFFFEB on cycle 34; MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF → DONE after 1 cycle, quotient 0x80000000; DIVU 9/0 → 0xFFFFFFFF; REM 9/0 → 9; REM -7/2 → 0xFFFFFFFF.
- DIVU 100/7 with mem_bubble_i pulsed in CALC cycle 10 → FSM IDLE next cycle, mem_valid_o=0, no write; a following ADD completes normally.
- MULH 0x40000000² with mem_stall_i held 3 cycles at DONE → result 0x10000000 is held, ex_stall_o=1, captured on the first unstalled edge, exactly one mem_valid_o pulse.
- rst_i pulled low mid-CALC → all mem_* outputs 0 immediately, ex_stall_o=0; after release a DIVU 10/3 yields 3.
